muldiv_issue: RTL and testbench

MULDIV_ISSUE -- requirements
Module: muldiv_issue

---
 rtl/muldiv_issue.sv | 143 ++++++++++++++
 tb/tb_muldiv_issue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue.sv
// -----------------------------------------------------------------------------
// muldiv_issue
//   Issue/writeback sequencer that sits between decode and the MULDIV2
//   iterative multiply/divide unit. It handles one M-extension operation at a
//   time. It latches the operands, pulses the unit's start, and waits for the
//   unit to go idle. It then captures the result and hands it to writeback
//   unless the op was flushed or targets x0.
//
// Ports
//   clk, rstLow        : rising-edge clock, asynchronous active-low reset
//   req_valid_i/ready_o: decode-side request handshake
//   req_funct3_i, req_rs1_i, req_rs2_i, req_rd_i : request payload
//   flush_i            : kills the in-flight result (the unit still finishes)
//   md_rs1_o, md_rs2_o, md_funct3_o, md_start_o  : drive MULDIV2 inputs
//   md_c_i, md_busy_i  : MULDIV2 result and busy
//   wb_valid_o, wb_rd_o, wb_data_o, wb_ready_i   : writeback handshake
//   busy_o             : an operation is in flight (state != IDLE)
//   lat_o              : edges from accept to capture of the last operation
// -----------------------------------------------------------------------------
module muldiv_issue #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstLow,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [2:0]       req_funct3_i,
   input  logic [31:0]      req_rs1_i,
   input  logic [31:0]      req_rs2_i,
   input  logic [4:0]       req_rd_i,
   input  logic             flush_i,
   output logic [31:0]      md_rs1_o,
   output logic [31:0]      md_rs2_o,
   output logic [2:0]       md_funct3_o,
   output logic             md_start_o,
   input  logic [31:0]      md_c_i,
   input  logic             md_busy_i,
   output logic             wb_valid_o,
   output logic [4:0]       wb_rd_o,
   output logic [31:0]      wb_data_o,
   input  logic             wb_ready_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] lat_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_GAP   = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [2:0]        r_funct3;
   logic [31:0]       r_rs1;
   logic [31:0]       r_rs2;
   logic [4:0]        r_rd;
   logic              r_kill;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_lat;
   logic [31:0]       r_wb_data;

   logic              w_accept;
   logic              w_capture;
   logic              w_live;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign w_accept  = (r_state == S_IDLE) && req_valid_i;
   assign w_capture = (r_state == S_WAIT) && !md_busy_i;
   // A flush on the capture edge itself still kills the result.
   assign w_live    = !(r_kill || flush_i) && (r_rd != 5'd0);

   // State register
   always_ff @(posedge clk or negedge rstLow) begin
      if (!rstLow) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid_i) w_next = S_START;
         S_START: w_next = S_GAP;
         S_GAP:   w_next = S_WAIT;
         S_WAIT:  if (!md_busy_i) w_next = w_live ? S_DONE : S_IDLE;
         S_DONE:  if (wb_ready_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      req_ready_o = (r_state == S_IDLE);
      md_start_o  = (r_state == S_START);
      wb_valid_o  = (r_state == S_DONE);
      busy_o      = (r_state != S_IDLE);
   end

   // Holding registers, kill flag, latency counter and result capture
   always_ff @(posedge clk or negedge rstLow) begin
      if (!rstLow) begin
         r_funct3  <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_kill    <= 1'b0;
         r_cnt     <= '0;
         r_lat     <= '0;
         r_wb_data <= '0;
      end else if (w_accept) begin
         r_funct3 <= req_funct3_i;
         r_rs1    <= req_rs1_i;
         r_rs2    <= req_rs2_i;
         r_rd     <= req_rd_i;
         r_kill   <= flush_i;
         r_cnt    <= '0;
      end else if (r_state == S_START || r_state == S_GAP || r_state == S_WAIT) begin
         r_kill <= r_kill | flush_i;
         r_cnt  <= sat_inc(r_cnt);
         if (w_capture) begin
            r_wb_data <= md_c_i;
            // Include the capture edge itself in the reported latency.
            r_lat     <= sat_inc(r_cnt);
         end
      end
   end

   assign md_rs1_o    = r_rs1;
   assign md_rs2_o    = r_rs2;
   assign md_funct3_o = r_funct3;
   assign wb_rd_o     = r_rd;
   assign wb_data_o   = r_wb_data;
   assign lat_o       = r_lat;

endmodule

// File: tb/tb_muldiv_issue.sv
module tb_muldiv_issue;

   logic        clk = 1'b0;
   logic        rstLow;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_rs1_i;
   logic [31:0] req_rs2_i;
   logic [4:0]  req_rd_i;
   logic        flush_i;
   logic [31:0] md_rs1_o;
   logic [31:0] md_rs2_o;
   logic [2:0]  md_funct3_o;
   logic        md_start_o;
   logic [31:0] md_c_i;
   logic        md_busy_i;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        wb_ready_i;
   logic        busy_o;
   logic [7:0]  lat_o;

   muldiv_issue #(.CNT_W(8)) dut (
      .clk(clk), .rstLow(rstLow),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_funct3_i(req_funct3_i), .req_rs1_i(req_rs1_i),
      .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i),
      .flush_i(flush_i),
      .md_rs1_o(md_rs1_o), .md_rs2_o(md_rs2_o),
      .md_funct3_o(md_funct3_o), .md_start_o(md_start_o),
      .md_c_i(md_c_i), .md_busy_i(md_busy_i),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
      .wb_data_o(wb_data_o), .wb_ready_i(wb_ready_i),
      .busy_o(busy_o), .lat_o(lat_o)
   );

   always #5 clk = ~clk;

   // Stand-in for MULDIV2: busy for busy_n cycles after a start pulse,
   // result computed from the operands it is driven with.
   int busy_n = 0;
   int rem    = 0;
   always @(posedge clk) begin
      if (md_start_o)   rem <= busy_n;
      else if (rem != 0) rem <= rem - 1;
   end
   assign md_busy_i = (rem != 0);

   always_comb begin
      md_c_i = 32'd0;
      case (md_funct3_o)
         3'd0: md_c_i = md_rs1_o * md_rs2_o;
         3'd4: md_c_i = 32'($signed(md_rs1_o) / $signed(md_rs2_o));
         3'd5: md_c_i = md_rs1_o / md_rs2_o;
         3'd6: md_c_i = 32'($signed(md_rs1_o) % $signed(md_rs2_o));
         3'd7: md_c_i = md_rs1_o % md_rs2_o;
         default: md_c_i = 32'd0;
      endcase
   end

   // Event counters sampled on the active edge
   int starts = 0;
   int wbs    = 0;
   always @(posedge clk) begin
      if (md_start_o) starts <= starts + 1;
      if (wb_valid_o) wbs    <= wbs + 1;
   end

   typedef struct {
      int          rd;
      logic [31:0] data;
      int          lat;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int rd, input logic [31:0] data, input int lat, input int cyc);
      exp_t e;
      e.rd = rd; e.data = data; e.lat = lat; e.cyc = cyc;
      sb.push_back(e);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after accept.
   task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int nb);
      chk("req_ready_before_accept", 32'(req_ready_o), 32'd1);
      req_valid_i  = 1'b1;
      req_funct3_i = f3;
      req_rs1_i    = a;
      req_rs2_i    = b;
      req_rd_i     = rd;
      busy_n       = nb;
      @(posedge clk);
      @(negedge clk);
      req_valid_i  = 1'b0;
      req_rs1_i    = 32'hDEAD_BEEF;
      req_rs2_i    = 32'hDEAD_BEEF;
      req_rd_i     = 5'd31;
   endtask

   // Waits for wb_valid_o and compares against the oldest scoreboard entry.
   task automatic wait_wb(input string tag, input int max);
      int   n;
      exp_t e;
      n = 0;
      while (wb_valid_o !== 1'b1 && n < max) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd1);
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_cycles"}, 32'(n), 32'(e.cyc));
         chk({tag, "_wb_rd"}, 32'(wb_rd_o), 32'(e.rd));
         chk({tag, "_wb_data"}, wb_data_o, e.data);
         chk({tag, "_lat"}, 32'(lat_o), 32'(e.lat));
      end
   endtask

   // Waits for busy_o to drop; n counts edges from the call.
   task automatic wait_idle(input int max, output int n);
      n = 0;
      while (busy_o !== 1'b0 && n < max) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int s0, w0, n, m;
      rstLow       = 1'b0;
      req_valid_i  = 1'b0;
      req_funct3_i = 3'd0;
      req_rs1_i    = 32'd0;
      req_rs2_i    = 32'd0;
      req_rd_i     = 5'd0;
      flush_i      = 1'b0;
      wb_ready_i   = 1'b1;
      #1;
      chk("rst_md_start", 32'(md_start_o), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_lat", 32'(lat_o), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd_o), 32'd0);
      chk("rst_wb_data", wb_data_o, 32'd0);
      chk("rst_md_rs1", md_rs1_o, 32'd0);
      repeat (3) @(negedge clk);
      rstLow = 1'b1;
      chk("post_rst_ready", 32'(req_ready_o), 32'd1);

      // MUL 3*5 -> x7, no busy: wb on the 4th edge counting the accept
      s0 = starts;
      push(7, 32'd15, 3, 3);
      do_req(3'd0, 32'd3, 32'd5, 5'd7, 0);
      wait_wb("mul", 10);
      @(posedge clk); @(negedge clk);
      chk("mul_start_pulses", 32'(starts - s0), 32'd1);
      chk("mul_back_idle", 32'(req_ready_o), 32'd1);
      chk("mul_busy_clear", 32'(busy_o), 32'd0);

      // DIVU 100/7 -> x9, 33 busy cycles
      s0 = starts;
      push(9, 32'd14, 35, 35);
      do_req(3'd5, 32'd100, 32'd7, 5'd9, 33);
      wait_wb("divu", 60);
      chk("divu_hold_rs1", md_rs1_o, 32'd100);
      chk("divu_hold_rs2", md_rs2_o, 32'd7);
      chk("divu_hold_f3", 32'(md_funct3_o), 32'd5);
      @(posedge clk); @(negedge clk);
      chk("divu_start_pulses", 32'(starts - s0), 32'd1);

      // REMU 50%8 -> x3, writeback stalled 5 cycles; flush in DONE is ignored
      push(3, 32'd2, 4, 4);
      wb_ready_i = 1'b0;
      do_req(3'd7, 32'd50, 32'd8, 5'd3, 2);
      wait_wb("stall", 10);
      for (int i = 0; i < 5; i++) begin
         flush_i = (i == 2 || i == 3);
         @(posedge clk); @(negedge clk);
         chk("stall_wb_valid", 32'(wb_valid_o), 32'd1);
         chk("stall_wb_rd", 32'(wb_rd_o), 32'd3);
         chk("stall_wb_data", wb_data_o, 32'd2);
         chk("stall_req_ready", 32'(req_ready_o), 32'd0);
      end
      flush_i    = 1'b0;
      wb_ready_i = 1'b1;
      req_valid_i = 1'b1;
      req_funct3_i = 3'd0; req_rs1_i = 32'd6; req_rs2_i = 32'd7; req_rd_i = 5'd4;
      @(posedge clk); @(negedge clk);
      chk("handshake_idle", 32'(req_ready_o), 32'd1);
      chk("handshake_no_accept", 32'(busy_o), 32'd0);
      req_valid_i = 1'b0;
      push(4, 32'd42, 3, 3);
      do_req(3'd0, 32'd6, 32'd7, 5'd4, 0);
      chk("next_start", 32'(md_start_o), 32'd1);
      wait_wb("after_stall", 10);
      @(posedge clk); @(negedge clk);

      // DIV with flush pulsed in WAIT while unit busy: discarded
      w0 = wbs;
      do_req(3'd4, -32'sd100, 32'd7, 5'd5, 10);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk); @(negedge clk);
      flush_i = 1'b0;
      chk("flush_still_busy", 32'(busy_o), 32'd1);
      wait_idle(40, m);
      chk("flush_idle_edge", 32'(3 + m), 32'd12);
      chk("flush_no_wb", 32'(wbs - w0), 32'd0);
      chk("flush_ready", 32'(req_ready_o), 32'd1);
      chk("flush_lat", 32'(lat_o), 32'd12);

      // REM into x0: runs, discarded, latency still reported
      w0 = wbs;
      do_req(3'd6, 32'd17, 32'd5, 5'd0, 4);
      wait_idle(20, n);
      chk("rd0_idle_edge", 32'(n), 32'd6);
      chk("rd0_no_wb", 32'(wbs - w0), 32'd0);
      chk("rd0_lat", 32'(lat_o), 32'd6);

      // Latency counter saturation
      push(2, 32'd1000000, 255, 302);
      do_req(3'd0, 32'd1000, 32'd1000, 5'd2, 300);
      wait_wb("sat", 400);
      @(posedge clk); @(negedge clk);

      // Reset during WAIT
      w0 = wbs;
      do_req(3'd7, 32'd77, 32'd10, 5'd6, 20);
      repeat (3) begin @(posedge clk); @(negedge clk); end
      rstLow = 1'b0;
      #1;
      chk("midrst_md_start", 32'(md_start_o), 32'd0);
      chk("midrst_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_lat", 32'(lat_o), 32'd0);
      chk("midrst_wb_rd", 32'(wb_rd_o), 32'd0);
      chk("midrst_wb_data", wb_data_o, 32'd0);
      chk("midrst_md_rs1", md_rs1_o, 32'd0);
      @(negedge clk);
      rstLow = 1'b1;
      chk("midrst_ready", 32'(req_ready_o), 32'd1);
      repeat (30) @(negedge clk);
      chk("midrst_no_wb", 32'(wbs - w0), 32'd0);
      push(8, 32'd143, 3, 3);
      do_req(3'd0, 32'd11, 32'd13, 5'd8, 0);
      wait_wb("post_rst", 10);
      @(posedge clk); @(negedge clk);
      chk("post_rst_idle", 32'(busy_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
